adc_sample_conditioner: RTL

- Sits between the Zmod ADC1410 controller outputs and the IAGC loop.
- Takes NUM_CHANNELS raw ADC words, truncates them to DATA_WIDTH signed samples and averages 2^DECIM_LOG2 samples per output.
- Reports per-channel near-clipping flags to the IAGC.
- Blanks output for a settle window after every IAGC status (gain/coupling relay) change.
- Generalises the fixed 2-channel, 16-to-14-bit, no-settling front end to N channels, configurable widths, decimation and settling.

---
 rtl/adc_sample_conditioner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/adc_sample_conditioner.sv
// rtl/adc_sample_conditioner.sv - N-channel ADC truncate/average/clip front end with IAGC settle blanking; ADC_ROUND_SATURATE_EN selects round+saturate
module adc_sample_conditioner #(
    parameter int NUM_CHANNELS     = 2,
    parameter int ADC_IN_WIDTH     = 16,
    parameter int DATA_WIDTH       = 14,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int DECIM_LOG2       = 2,
    parameter int SETTLE_SAMPLES   = 64,
    parameter int CLIP_MARGIN      = 8
) (
    input  logic                               i_sys_clock,
    input  logic                               i_reset_n,
    input  logic [IAGC_STATUS_SIZE-1:0]        i_iagc_status,
    input  logic                               i_adc_init_done,
    input  logic                               i_sample_valid,
    input  logic [NUM_CHANNELS*ADC_IN_WIDTH-1:0] i_adc_data,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_data,
    output logic                               o_data_valid,
    output logic [NUM_CHANNELS-1:0]            o_clip,
    output logic                               o_settling,
    output logic [1:0]                         o_state
);
    localparam int ACC_W = DATA_WIDTH + DECIM_LOG2;
    localparam int WIN_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int SET_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << DECIM_LOG2) - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_SAMPLES - 1);
    localparam logic signed [DATA_WIDTH-1:0] CLIP_HI = DATA_WIDTH'((1 << (DATA_WIDTH-1)) - 1 - CLIP_MARGIN);
    localparam logic signed [DATA_WIDTH-1:0] CLIP_LO = DATA_WIDTH'(-(1 << (DATA_WIDTH-1)) + CLIP_MARGIN);
`ifdef ADC_ROUND_SATURATE_EN
    localparam logic signed [ACC_W:0] RND_ADD = (ACC_W+1)'((DECIM_LOG2 > 0) ? (1 << (DECIM_LOG2-1)) : 0);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 << (DATA_WIDTH-1)));
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RUN = 2'd2} state_t;

    state_t                        state;
    logic [IAGC_STATUS_SIZE-1:0]   status_q;
    logic [SET_W-1:0]              settle_cnt;
    logic [WIN_W-1:0]              win_cnt;
    logic signed [ACC_W-1:0]       acc [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]       sticky;

    logic                          active;
    logic                          status_same;
    logic                          run_ok;
    logic                          win_last;
    logic                          unused_lsbs;
    logic signed [DATA_WIDTH-1:0]  sample [NUM_CHANNELS];
    logic signed [ACC_W-1:0]       sum    [NUM_CHANNELS];
    logic signed [DATA_WIDTH-1:0]  avg    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]       hit;
`ifdef ADC_ROUND_SATURATE_EN
    logic signed [ACC_W:0]         rnd    [NUM_CHANNELS];
`endif

    assign active      = (i_iagc_status != '0) && i_adc_init_done;
    assign status_same = (i_iagc_status == status_q);
    assign run_ok      = active && (state == RUN) && status_same;
    assign win_last    = (win_cnt == WIN_LAST);
    assign unused_lsbs = ^i_adc_data;
    assign o_state     = state;
    assign o_settling  = (state == SETTLE);

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sample[c] = i_adc_data[c*ADC_IN_WIDTH + ADC_IN_WIDTH-1 -: DATA_WIDTH];
            hit[c]    = (sample[c] >= CLIP_HI) || (sample[c] <= CLIP_LO);
            sum[c]    = acc[c] + ACC_W'(sample[c]);
`ifdef ADC_ROUND_SATURATE_EN
            rnd[c] = ((ACC_W+1)'(sum[c]) + RND_ADD) >>> DECIM_LOG2;
            if (rnd[c] > SAT_MAX)
                avg[c] = SAT_MAX[DATA_WIDTH-1:0];
            else if (rnd[c] < SAT_MIN)
                avg[c] = SAT_MIN[DATA_WIDTH-1:0];
            else
                avg[c] = rnd[c][DATA_WIDTH-1:0];
`else
            avg[c] = DATA_WIDTH'(sum[c] >>> DECIM_LOG2);
`endif
        end
    end

    // Status change in SETTLE/RUN restarts the settle count; the relay needs time to settle
    always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            status_q   <= '0;
            settle_cnt <= '0;
        end else if (!active) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                    status_q   <= i_iagc_status;
                end
                SETTLE, RUN: begin
                    if (!status_same) begin
                        state      <= SETTLE;
                        status_q   <= i_iagc_status;
                        settle_cnt <= '0;
                    end else if (state == SETTLE && i_sample_valid) begin
                        if (settle_cnt == SET_LAST)
                            state <= RUN;
                        else
                            settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Any cycle not continuing a RUN window discards the partial window
    always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= '0;
            win_cnt      <= '0;
            sticky       <= '0;
            o_data       <= '0;
            o_clip       <= '0;
            o_data_valid <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            if (!run_ok) begin
                for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= '0;
                win_cnt <= '0;
                sticky  <= '0;
            end else if (i_sample_valid) begin
                if (win_last) begin
                    for (int c = 0; c < NUM_CHANNELS; c++) begin
                        o_data[c*DATA_WIDTH +: DATA_WIDTH] <= avg[c];
                        acc[c] <= '0;
                    end
                    o_clip       <= sticky | hit;
                    sticky       <= '0;
                    win_cnt      <= '0;
                    o_data_valid <= 1'b1;
                end else begin
                    for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= sum[c];
                    sticky  <= sticky | hit;
                    win_cnt <= win_cnt + 1'b1;
                end
            end
        end
    end
endmodule
